// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for a picorv32-style memory bus.
// One master owns the downstream bus per transaction; a watchdog converts a
// slave that never answers into an error response so neither master can hang.
module mem_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic [31:0] s0_addr,
    input  logic [3:0]  s0_wstrb,
    input  logic [31:0] s0_wdata,
    output logic [31:0] s0_rdata,
    output logic        s0_ready,
    output logic        s0_error,
    input  logic        s1_valid,
    input  logic [31:0] s1_addr,
    input  logic [3:0]  s1_wstrb,
    input  logic [31:0] s1_wdata,
    output logic [31:0] s1_rdata,
    output logic        s1_ready,
    output logic        s1_error,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    input  logic        m_error,
    output logic        grant,
    output logic        busy,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // TIMEOUT >= 2, so TIMEOUT-1 always fits in clog2(TIMEOUT) bits.
    localparam int              CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic            last_grant_reg, last_grant_next;
    logic            grant_reg, grant_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [7:0]      timeout_count_reg, timeout_count_next;

    logic            owner;
    logic            done;
    logic            expire;
    logic            resp_ready;
    logic            resp_error;

    // Read data is shared; only the owning master gets a ready pulse.
    assign s0_rdata      = m_rdata;
    assign s1_rdata      = m_rdata;
    assign grant         = grant_reg;
    assign busy          = (state_reg != IDLE);
    assign timeout_count = timeout_count_reg;

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            last_grant_reg    <= 1'b1;
            grant_reg         <= 1'b0;
            wait_cnt_reg      <= '0;
            timeout_count_reg <= 8'd0;
        end else begin
            state_reg         <= state_next;
            last_grant_reg    <= last_grant_next;
            grant_reg         <= grant_next;
            wait_cnt_reg      <= wait_cnt_next;
            timeout_count_reg <= timeout_count_next;
        end
    end

    // Arbitration, request routing, response steering and watchdog.
    always_comb begin
        state_next         = state_reg;
        last_grant_next    = last_grant_reg;
        grant_next         = grant_reg;
        wait_cnt_next      = wait_cnt_reg;
        timeout_count_next = timeout_count_reg;
        owner              = 1'b0;
        done               = 1'b0;
        expire             = 1'b0;
        resp_ready         = 1'b0;
        resp_error         = 1'b0;
        m_valid            = 1'b0;
        m_addr             = 32'd0;
        m_wstrb            = 4'd0;
        m_wdata            = 32'd0;
        s0_ready           = 1'b0;
        s0_error           = 1'b0;
        s1_ready           = 1'b0;
        s1_error           = 1'b0;

        case (state_reg)
            IDLE: begin
                // On a tie the master that did not win last time goes first.
                if (s0_valid && (!s1_valid || last_grant_reg)) begin
                    state_next      = GRANT0;
                    last_grant_next = 1'b0;
                    grant_next      = 1'b0;
                    wait_cnt_next   = '0;
                end else if (s1_valid) begin
                    state_next      = GRANT1;
                    last_grant_next = 1'b1;
                    grant_next      = 1'b1;
                    wait_cnt_next   = '0;
                end
            end

            GRANT0, GRANT1: begin
                owner   = (state_reg == GRANT1);
                m_valid = owner ? s1_valid : s0_valid;
                m_addr  = owner ? s1_addr  : s0_addr;
                m_wstrb = owner ? s1_wstrb : s0_wstrb;
                m_wdata = owner ? s1_wdata : s0_wdata;

                // A real slave response in the last watchdog cycle wins.
                done       = m_valid && (m_ready || m_error);
                expire     = m_valid && !done && (wait_cnt_reg == WAIT_LAST);
                resp_ready = m_valid && m_ready;
                resp_error = m_valid && (m_error || expire);

                s0_ready = !owner && resp_ready;
                s0_error = !owner && resp_error;
                s1_ready =  owner && resp_ready;
                s1_error =  owner && resp_error;

                // A master dropping valid mid-transaction just releases the bus.
                if (!m_valid || done || expire) begin
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CW'(1);
                end

                if (expire && (timeout_count_reg != 8'hFF)) begin
                    timeout_count_next = timeout_count_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
